seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. It is the next generation of the team's fixed-pattern FSM_a detector.
- Pattern width, pattern value and overlap mode are generics. Adds an input-valid qualifier and a saturating match counter.
- Sits on a 1-bit serial input stream and flags each completed occurrence of PATTERN with a registered Moore output.

Parameters:
- PATTERN_W, 4, pattern length in bits (>=1; max 16).
- PATTERN, 4'b1011, pattern value; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = after a match, detection restarts from an empty prefix.
- CNT_W, 8, width of the match counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- x_in  input  1  serial data bit.
- x_valid  input  1  x_in is sampled only when high.
- y_out  output  1  Moore match flag: high while the FSM is in the full-match state.
- match_count  output  CNT_W  number of completed matches since reset; saturates.
- count_sat  output  1  high once match_count has reached its all-ones value.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-high and is sampled at the CLK rising edge.
- Reset values: state S0, y_out 0, match_count 0, count_sat 0. Reset has priority over x_valid.
- State encoding: S0..S(PATTERN_W), where state k means the last k accepted bits equal the first k bits of PATTERN. State register width is clog2(PATTERN_W+1).
- Next state from Sk (k < PATTERN_W) on accepted bit b: length of the longest suffix of (PATTERN prefix of length k, followed by b) that is also a PATTERN prefix. This is the KMP failure-function transition, computed combinationally from the parameters. No pattern-specific hand-coded states.
- Next state from S(PATTERN_W) on accepted bit b:
  - OVERLAP=1: same rule as above, applied to the full pattern followed by b.
  - OVERLAP=0: the transition S0 would take on b.
- x_valid=0: state, y_out and match_count all hold. y_out therefore stays high across valid gaps after a match.
- y_out = (state == S(PATTERN_W)), registered. Latency: y_out rises in the cycle after the rising edge that accepted the final pattern bit.
- match_count increments by 1 on every accepted bit whose next state is S(PATTERN_W). This includes consecutive matches S(PW)->S(PW) when OVERLAP=1 (possible only for a single-bit or all-equal-bit pattern).
- Saturation: at 2^CNT_W-1, match_count holds and count_sat=1. count_sat clears only on Reset.
- PATTERN_W=1: the FSM has S0 and S1; y_out follows each accepted bit equal to PATTERN.
- Reset mid-match: any partial prefix is discarded and detection restarts; bits accepted before the reset never contribute to a match.
- Out-of-range parameters (PATTERN_W<1 or >16, CNT_W<1): elaboration-time error.

Decomposition:
- Package seq_detector_pkg:
  - a clog2 constant function;
  - a constant function next_state(pattern, width, k, b) implementing the suffix/prefix rule.
- One combinational sub-module, seq_detector_next. Inputs: current state, bit, overlap. Output: next state. It is built as a generate-time lookup table of 2*(PATTERN_W+1) entries.
- Top level holds the state register, the output register and the counter.

Test Plan:
- Default parameters (1011, OVERLAP=1), x_valid=1, stream 1,0,1,1,0,1,1 -> y_out high in the cycles after samples 4 and 7 only; final match_count=2.
- Same stream with OVERLAP=0 -> y_out high only after sample 4; match_count=1.
- PATTERN=3'b111, PATTERN_W=3, stream of five 1s:
  - OVERLAP=1 -> y_out high after samples 3, 4 and 5; count=3.
  - OVERLAP=0 -> y_out high after sample 3 only; count=1.
- Default parameters, stream 1,0,1 then x_valid=0 for 3 cycles, then 1 -> no match during the gap; y_out rises after the final bit; count=1. Then x_valid=0 for 2 cycles -> y_out holds 1 and count holds 1.
- Default parameters, 1,0,1 then Reset=1 for one cycle (x_in=1, x_valid=1), then 1,0,1,1 -> no match from the pre-reset prefix; match after the fourth post-reset bit; count=1.
- CNT_W=2, default pattern, stream 1011 repeated 5 times -> match_count goes 1,2,3 and stays 3; count_sat=1 from the third match onward.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Purpose : shared constants and elaboration-time helpers for the serial pattern detector.
// Latency : n/a (constant functions only, evaluated at elaboration).
// Backpr. : n/a.
// Contents: MAX_PATTERN_W, clog2(), pat_bit(), next_state() (prefix-automaton transition rule).
package seq_detector_pkg;

  // Widest pattern the detector supports.
  localparam int MAX_PATTERN_W = 16;

  // Ceiling log2, never less than 1 so a register always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Bit i of the pattern in arrival order (i = 0 is the first bit received,
  // which is the MSB of the parameter). Out-of-range positions read as 0.
  function automatic logic pat_bit(input logic [MAX_PATTERN_W-1:0] pattern,
                                   input int width, input int i);
    logic r;
    r = 1'b0;
    if (i >= 0 && i < width) r = pattern[width-1-i];
    return r;
  endfunction

  // Transition of the prefix automaton: from state k (the last k accepted
  // bits equal the first k pattern bits) on bit b, return the length of the
  // longest suffix of (pattern[0..k-1], b) that is also a pattern prefix.
  // A state can never exceed width, so candidate lengths are capped there;
  // this makes the same rule serve the full-match state for overlap mode.
  function automatic int next_state(input logic [MAX_PATTERN_W-1:0] pattern,
                                    input int width, input int k, input int b);
    logic [MAX_PATTERN_W:0] s;
    int  max_len;
    int  result;
    bit  found;
    bit  ok;
    s = '0;
    for (int i = 0; i < MAX_PATTERN_W; i++) begin
      if (i < k) s[i] = pat_bit(pattern, width, i);
    end
    s[k] = b[0];
    max_len = (k + 1 < width) ? (k + 1) : width;
    result  = 0;
    found   = 1'b0;
    for (int len = MAX_PATTERN_W; len >= 1; len--) begin
      if (!found && len <= max_len) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PATTERN_W; i++) begin
          if (i < len && s[k+1-len+i] != pat_bit(pattern, width, i)) ok = 1'b0;
        end
        if (ok) begin
          result = len;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_detector_next.sv
// Purpose : combinational next-state lookup for the pattern detector.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller decides whether the result is committed.
// Ports   : cur_state - current automaton state S0..S(PATTERN_W)
//           bit_in    - serial bit being accepted
//           overlap   - 1: full-match state continues via suffix rule, 0: restart from S0
//           nxt_state - resulting state
module seq_detector_next
  import seq_detector_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   ST_W      = clog2(PATTERN_W + 1)
) (
  input  logic [ST_W-1:0] cur_state,
  input  logic            bit_in,
  input  logic            overlap,
  output logic [ST_W-1:0] nxt_state
);

  // Entry 2*k+b holds the transition from Sk on bit b. The row for the
  // full-match state holds the overlapping transition; the non-overlap
  // case reuses the S0 row instead.
  localparam int N_ENT = 2 * (PATTERN_W + 1);

  logic [ST_W-1:0] lut [N_ENT];

  for (genvar g = 0; g < N_ENT; g++) begin : g_lut
    localparam logic [ST_W-1:0] ENT =
      ST_W'(next_state(16'(PATTERN), PATTERN_W, g / 2, g % 2));
    assign lut[g] = ENT;
  end

  // Encodings above S(PATTERN_W) are unreachable; they fall back to S0.
  always_comb begin
    nxt_state = '0;
    for (int i = 0; i <= PATTERN_W; i++) begin
      if (cur_state == ST_W'(i)) begin
        if (i == PATTERN_W && !overlap) begin
          nxt_state = bit_in ? lut[1] : lut[0];
        end else begin
          nxt_state = bit_in ? lut[2*i+1] : lut[2*i];
        end
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Purpose : parametrised serial pattern detector with Moore match flag and saturating match counter.
// Latency : y_out rises one cycle after the edge that accepts the last pattern bit.
// Backpr. : none; x_valid=0 freezes state, y_out and match_count.
// Ports   : CLK, Reset (sync, active-high), x_in/x_valid (serial input + qualifier),
//           y_out (match flag), match_count (saturating count), count_sat (sticky saturation flag).
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             x_in,
  input  logic             x_valid,
  output logic             y_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  if (PATTERN_W < 1 || PATTERN_W > MAX_PATTERN_W || CNT_W < 1) begin : g_bad_param
    $error("seq_detector_param: PATTERN_W must be 1..16 and CNT_W >= 1");
  end

  localparam int              ST_W   = clog2(PATTERN_W + 1);
  localparam logic [ST_W-1:0] S_IDLE = '0;
  localparam logic [ST_W-1:0] S_FULL = ST_W'(PATTERN_W);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  nxt_state;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;

  seq_detector_next #(
    .PATTERN_W (PATTERN_W),
    .PATTERN   (PATTERN),
    .ST_W      (ST_W)
  ) u_next (
    .cur_state (state),
    .bit_in    (x_in),
    .overlap   (OVERLAP),
    .nxt_state (nxt_state)
  );

  // A match is counted on every accepted bit that lands in the full state,
  // including full->full steps for single-bit or all-equal patterns.
  assign hit     = (nxt_state == S_FULL);
  assign cnt_inc = match_count + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      y_out       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (x_valid) begin
      state <= nxt_state;
      // Registered copy of (next state == full), so y_out tracks state exactly.
      y_out <= hit;
      if (hit && !count_sat) begin
        match_count <= cnt_inc;
        // Saturation is sticky: once the all-ones value is reached the
        // counter stops and only Reset clears the flag.
        if (&cnt_inc) count_sat <= 1'b1;
      end
    end
  end

endmodule
